// File: rtl/cache_mem_stage_pkg.sv
// Shared constants for the MEM-stage cache: FSM encoding, address field offsets, line geometry.
// Two 32-bit words per 64-bit line; word 0 sits in the low half.
package cache_mem_stage_pkg;

  localparam int WORD_W   = 32;
  localparam int LINE_W   = 64;
  localparam int WORD_BIT = 2;  // addr bit selecting the word within a line
  localparam int IDX_LSB  = 3;  // first index bit; also the line offset width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WTHRU
  } state_e;

  function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line, input logic sel);
    return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cache_mem_stage_if.sv
// Pipeline request/response and SRAM controller signals of the MEM-stage cache.
// slave = cache side, master = pipeline + SRAM side.
interface cache_mem_stage_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_re;
  logic        sram_we;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_addr, sram_wdata, sram_re, sram_we
  );

  modport master (
    output mem_r_en, mem_w_en, addr, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_addr, sram_wdata, sram_re, sram_we
  );

endinterface

// File: rtl/cache_mem_stage_way_array.sv
// One cache way: per-set valid, tag and 64-bit line; combinational read at idx.
// Writes land at the clock edge; a line fill takes precedence over a word store; reset clears valids only.
module cache_way_array
  import cache_mem_stage_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              fill_we,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              store_we,
  input  logic              word_sel,
  input  logic [WORD_W-1:0] store_word,
  output logic              vld_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o
);

  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [LINE_W-1:0] line_q [SETS];
  logic [LINE_W-1:0] line_d [SETS];

  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    line_d = line_q;
    if (fill_we) begin
      vld_d[idx]  = 1'b1;
      tag_d[idx]  = tag_i;
      line_d[idx] = fill_line;
    end else if (store_we) begin
      if (word_sel) line_d[idx][LINE_W-1:WORD_W] = store_word;
      else          line_d[idx][WORD_W-1:0]      = store_word;
    end
  end

  // Tag/data keep their contents through reset; valid bits alone define emptiness.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      line_q <= line_d;
    end
  end

  assign vld_o  = vld_q[idx];
  assign tag_o  = tag_q[idx];
  assign line_o = line_q[idx];

endmodule

// File: rtl/cache_mem_stage.sv
// MEM-stage 2-way set-associative write-through, no-write-allocate cache; CACHE_STATS_EN adds hit/miss counters.
// Load hit 0 cycles, miss 1 + SRAM wait; stores wait for SRAM; ready=0 freezes the pipeline.
module cache_mem_stage
  import cache_mem_stage_pkg::*;
#(
  parameter int SETS   = 64,
  parameter int ADDR_W = 16,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CACHE_STATS_EN
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count,
`endif
  cache_mem_stage_if.slave  bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_LSB - IDX_W;

  state_e            state_q, state_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic              sram_re_q, sram_re_d;
  logic              sram_we_q, sram_we_d;
  logic [31:0]       sram_addr_q, sram_addr_d;
  logic [31:0]       sram_wdata_q, sram_wdata_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              word_sel;
  logic [1:0]        way_vld, hit_vec, fill_we, store_we;
  logic [TAG_W-1:0]  way_tag  [2];
  logic [LINE_W-1:0] way_line [2];
  logic              hit, hit_way, victim;
  logic [WORD_W-1:0] hit_word;

  assign idx      = bus.addr[IDX_LSB +: IDX_W];
  assign tag      = bus.addr[IDX_LSB + IDX_W +: TAG_W];
  assign word_sel = bus.addr[WORD_BIT];

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_way (
      .clk        (clk),
      .rst        (rst),
      .idx        (idx),
      .tag_i      (tag),
      .fill_we    (fill_we[w]),
      .fill_line  (bus.sram_rdata),
      .store_we   (store_we[w]),
      .word_sel   (word_sel),
      .store_word (bus.wdata),
      .vld_o      (way_vld[w]),
      .tag_o      (way_tag[w]),
      .line_o     (way_line[w])
    );
    assign hit_vec[w] = way_vld[w] && (way_tag[w] == tag);
  end

  assign hit      = |hit_vec;
  assign hit_way  = hit_vec[1];
  assign hit_word = pick_word(way_line[hit_way], word_sel);

  // Fill an empty way first; only a full set consults LRU.
  always_comb begin
    if (!way_vld[0])      victim = 1'b0;
    else if (!way_vld[1]) victim = 1'b1;
    else                  victim = lru_q[idx];
  end

  always_comb begin
    state_d      = state_q;
    lru_d        = lru_q;
    sram_re_d    = sram_re_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    fill_we      = '0;
    store_we     = '0;
    bus.ready    = 1'b0;
    bus.rdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_w_en) begin
          state_d      = ST_WTHRU;
          sram_we_d    = 1'b1;
          sram_addr_d  = bus.addr;
          sram_wdata_d = bus.wdata;
          if (hit) begin
            store_we[hit_way] = 1'b1;
            lru_d[idx]        = ~hit_way;
          end
        end else if (bus.mem_r_en) begin
          if (hit) begin
            bus.ready  = 1'b1;
            bus.rdata  = hit_word;
            lru_d[idx] = ~hit_way;
          end else begin
            state_d     = ST_FILL;
            sram_re_d   = 1'b1;
            sram_addr_d = {bus.addr[31:IDX_LSB], {IDX_LSB{1'b0}}};
          end
        end else begin
          bus.ready = 1'b1;
        end
      end
      ST_FILL: begin
        if (bus.sram_ready) begin
          bus.ready       = 1'b1;
          bus.rdata       = pick_word(bus.sram_rdata, word_sel);
          fill_we[victim] = 1'b1;
          lru_d[idx]      = ~victim;
          sram_re_d       = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      ST_WTHRU: begin
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          sram_we_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lru_q        <= '0;
      sram_re_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      lru_q        <= lru_d;
      sram_re_q    <= sram_re_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign bus.sram_re    = sram_re_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic              load_lookup;

  // Only loads seen in IDLE count; the FILL completion is not a second event.
  assign load_lookup = (state_q == ST_IDLE) && !bus.mem_w_en && bus.mem_r_en;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (load_lookup && hit)  hit_count_d  = hit_count_q + 1'b1;
    if (load_lookup && !hit) miss_count_d = miss_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_mem_stage.sv
// Bench for cache_mem_stage: SRAM behavioural model, request table with hand-derived hit/miss, rdata scoreboard.
// Build with CACHE_STATS_EN defined to also check the hit/miss counters.
module tb_cache_mem_stage;

  localparam int STAT_W = 32;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_miss;
  } vec_t;

  typedef struct packed {
    logic        is_load;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  cache_mem_stage_if bus();
`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_count, miss_count;
`endif

  cache_mem_stage #(.SETS(64), .ADDR_W(16), .STAT_W(STAT_W)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          sram_lat = 3;
  string       cur = "reset";
  exp_t        sb[$];
  logic [31:0] mem_w [logic [31:0]];
  vec_t        vt [19];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] k;
    k = {2'b00, a[31:2]};
    if (mem_w.exists(k)) return mem_w[k];
    return 32'hC0DE_0000 | {16'h0, a[15:0] & 16'hFFFC};
  endfunction

  // SRAM: pulses sram_ready after sram_lat cycles of a held request.
  initial begin
    int cnt;
    cnt = 0;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.sram_ready = 1'b0;
      if (bus.sram_re || bus.sram_we) begin
        if (cnt == sram_lat) begin
          cnt = 0;
          bus.sram_ready = 1'b1;
          if (bus.sram_we) mem_w[{2'b00, bus.sram_addr[31:2]}] = bus.sram_wdata;
          else bus.sram_rdata = {rd_word(bus.sram_addr | 32'h4), rd_word(bus.sram_addr)};
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge following completion.
  task automatic run_req(input vec_t v);
    exp_t e;
    int   cyc;
    bit   done;
    bit   st;
    st = v.we;
    e.is_load = !st;
    e.rdata   = (!st && v.re) ? rd_word(v.addr) : 32'h0;
    sb.push_back(e);
    bus.mem_r_en = v.re;
    bus.mem_w_en = v.we;
    bus.addr     = v.addr;
    bus.wdata    = v.wdata;
    cyc  = 0;
    done = 0;
    while (!done && cyc <= 40) begin
      @(negedge clk);
      if (cyc == 0) begin
        if (st || v.exp_miss) chk("stall", bus.ready, 0);
        else chk("no_sram_re", bus.sram_re, 0);
      end else if (st) begin
        chk("sram_we", bus.sram_we, 1);
        chk("sram_addr", bus.sram_addr, v.addr);
        chk("sram_wdata", bus.sram_wdata, v.wdata);
      end else begin
        chk("sram_re", bus.sram_re, 1);
        chk("sram_addr", bus.sram_addr, {v.addr[31:3], 3'b000});
      end
      if (bus.ready) begin
        done = 1;
        e = sb.pop_front();
        if (e.is_load) chk("rdata", bus.rdata, e.rdata);
        chk("latency", cyc, (st || v.exp_miss) ? sram_lat + 1 : 0);
      end else begin
        cyc++;
      end
    end
    if (!done) begin
      chk("ready_timeout", 0, 1);
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
  endtask

  initial begin
    // {re, we, addr, wdata, exp_miss}; set 0 holds A=0x400, B=0x600, C=0x800
    vt[0]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0404, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0000_0404, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, 1'b0};
    vt[10] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 32'h0000_0800, 32'hCAFE_F00D, 1'b0};
    vt[12] = '{1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b1};
    vt[13] = '{1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b1};
    vt[14] = '{1'b1, 1'b0, 32'h0000_0804, 32'h0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0, 1'b1};
    vt[16] = '{1'b1, 1'b0, 32'h0000_100C, 32'h0, 1'b0};
    vt[17] = '{1'b1, 1'b1, 32'h0000_0A00, 32'h5555_AAAA, 1'b0};
    vt[18] = '{1'b1, 1'b0, 32'h0000_0A00, 32'h0, 1'b1};

    mem_w[32'h0000_0100] = 32'h1111_2222;
    mem_w[32'h0000_0101] = 32'hAAAA_BBBB;

    rst          = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready", bus.ready, 1);
    chk("rdata", bus.rdata, 0);
    chk("sram_re", bus.sram_re, 0);
    chk("sram_we", bus.sram_we, 0);
    chk("sram_addr", bus.sram_addr, 0);
    chk("sram_wdata", bus.sram_wdata, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      cur = $sformatf("vec%0d", i);
      run_req(vt[i]);
`ifdef CACHE_STATS_EN
      if (i == 1) begin
        chk("hit_count", hit_count, 1);
        chk("miss_count", miss_count, 1);
      end
`endif
    end

    // Reset while a fill is outstanding: request dropped, next lookup misses again.
    cur = "rst_fill";
    sram_lat = 10;
    bus.mem_r_en = 1'b1;
    bus.addr     = 32'h0000_2000;
    @(negedge clk);
    chk("stall", bus.ready, 0);
    @(negedge clk);
    chk("sram_re_before", bus.sram_re, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_r_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("sram_re_after", bus.sram_re, 0);
    chk("ready_after", bus.ready, 1);
    chk("rdata_after", bus.rdata, 0);
`ifdef CACHE_STATS_EN
    chk("hit_count_rst", hit_count, 0);
    chk("miss_count_rst", miss_count, 0);
`endif
    @(posedge clk);
    #1;
    sram_lat = 3;
    cur = "rst_refill";
    run_req('{1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b1});
    cur = "rst_cleared";
    run_req('{1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b1});
    cur = "end";
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
